cp_alloc: RTL and testbench
===========================

Name: cp_alloc

Overview:
Checkpoint slot manager placed between rename/dispatch and the RAT checkpoint table. It hands out checkpoint indices to branches in program order and drives the checkpoint table's write strobe and index. On branch resolution it frees slots, or on a mispredict it selects the recovery slot and squashes all younger slots. Slots form an in-order circular queue.

Parameters:
CP_SIZE, 8, number of checkpoint slots; must equal `RAT_CP_SIZE and be a power of two.
IDX_W, $clog2(CP_SIZE), slot index width; matches cp_index_t.

Ports:
clock  input  1  single clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset: state clears on a posedge where reset==0.
flush  input  1  commit-time exception/flush; frees all slots.
alloc_req  input  1  a branch at rename requests a checkpoint this cycle.
alloc_ready  output  1  a slot is available (registered count < CP_SIZE and no mispredict this cycle).
alloc_idx  output  IDX_W  index granted; valid when alloc_req && alloc_ready.
check  output  1  write strobe to checkpoint table; equals alloc_req && alloc_ready.
check_idx  output  IDX_W  equals alloc_idx.
resolve_valid  input  1  a branch resolves this cycle.
resolve_idx  input  IDX_W  checkpoint slot of the resolving branch.
resolve_mispredict  input  1  the resolving branch was mispredicted.
recover  output  1  combinational: resolve_valid && resolve_mispredict && slot valid.
recover_idx  output  IDX_W  combinational: resolve_idx; drives checkpoint table read index.
cp_count  output  IDX_W+1  occupied slots (registered).
cp_empty  output  1  cp_count==0.

Behaviour:
- State: head and tail pointers of IDX_W+1 bits (MSB is a wrap bit); per-slot valid[] and done[].
- Reset values (reset==0 at posedge): head=0, tail=0, all valid/done=0, so cp_count=0, cp_empty=1, alloc_ready=1. check=0 and recover=0 unless inputs are asserted. Reset overrides everything, including mid-stream operation.
- cp_count = tail - head, modulo 2^(IDX_W+1). Full when cp_count==CP_SIZE.
- Allocation: fires when alloc_req && alloc_ready. It takes slot tail[IDX_W-1:0] and sets valid=1, done=0, then tail+1 (wraps naturally). Zero latency: alloc_idx and check are combinational from the current tail.
- alloc_ready is computed from registered state only. A slot freed in the same cycle does not make it ready, so a full queue stalls one cycle.
- Correct resolve (resolve_valid && !resolve_mispredict && valid[resolve_idx]) sets done[resolve_idx]=1. A resolve to an invalid slot is ignored.
- Release: each cycle, if valid[head] && done[head], clear that slot and head+1. At most one release per cycle; a slot resolved this cycle is released no earlier than the next cycle.
- Mispredict (resolve_valid && resolve_mispredict && valid[resolve_idx]):
  - recover=1 with recover_idx=resolve_idx in the same cycle.
  - Clear valid/done of resolve_idx and every younger slot up to tail-1.
  - Set tail = the pointer value of resolve_idx, with the wrap bit taken so that head <= tail.
  - Any allocation in that cycle is suppressed (alloc_ready=0).
  - A release of an older head slot in the same cycle still proceeds.
- Priority: reset > flush > mispredict > (alloc, resolve, release). flush sets tail=head, clears all valid/done, and drives recover=0.
- A mispredict on the slot at head with cp_count==1 leaves the queue empty.

Optional Feature:
CP_ALLOC_STATS_EN
- Defined: adds outputs stat_alloc_cnt, stat_mispredict_cnt and stat_full_stall_cnt, each 32 bits.
  - They count allocations, recoveries, and cycles with alloc_req && !alloc_ready respectively.
  - Each saturates at 2^32-1 and clears on reset (not on flush).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with alloc_req=1 -> check=0 through reset; after release cp_count=0, cp_empty=1, and the first grant is alloc_idx=0.
- Fill: alloc_req=1 for 9 cycles, no resolves -> grants 0..7, then alloc_ready=0 on cycle 9 with cp_count=8 and check=0.
- In-order release: allocate 0,1,2; resolve 1 correct, then resolve 0 correct -> head stays 0 until slot 0 is done, then releases 0 and 1 on consecutive cycles; cp_count goes 3->2->1.
- Mispredict squash: allocate 0..4; resolve_idx=2 with mispredict and alloc_req=1 in the same cycle -> recover=1, recover_idx=2, no grant; next cycle cp_count=2 and the next grant is alloc_idx=2.
- Wrap: run 12 allocate/resolve pairs -> indices wrap 7->0, cp_count never exceeds 8, and a full state with head=4 is detected correctly.
- Flush: with 5 slots live plus a simultaneous mispredict -> flush wins, recover=0, next cycle cp_count=0. Then resolve_idx=3 correct -> ignored.

Source files
------------

// File: rtl/cp_alloc.sv
// rtl/cp_alloc.sv - in-order circular checkpoint slot allocator with mispredict squash
// Optional statistics counters enabled by defining CP_ALLOC_STATS_EN.
module cp_alloc #(
  parameter int CP_SIZE = 8,
  parameter int IDX_W   = $clog2(CP_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_req,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             check,
  output logic [IDX_W-1:0] check_idx,
  input  logic             resolve_valid,
  input  logic [IDX_W-1:0] resolve_idx,
  input  logic             resolve_mispredict,
  output logic             recover,
  output logic [IDX_W-1:0] recover_idx,
  output logic [IDX_W:0]   cp_count,
  output logic             cp_empty
`ifdef CP_ALLOC_STATS_EN
  ,
  output logic [31:0]      stat_alloc_cnt,
  output logic [31:0]      stat_mispredict_cnt,
  output logic [31:0]      stat_full_stall_cnt
`endif
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0]      head, tail;
  logic [CP_SIZE-1:0] valid, done;
  logic [IDX_W-1:0]   head_idx, tail_idx, misp_off;
  logic               mispredict, resolve_ok, release_ok, alloc_fire;

  assign head_idx   = head[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign cp_count   = tail - head;
  assign cp_empty   = (cp_count == '0);

  assign mispredict = resolve_valid && resolve_mispredict && valid[resolve_idx];
  assign resolve_ok = resolve_valid && !resolve_mispredict && valid[resolve_idx];
  // Ready looks only at registered occupancy, so a same-cycle release never unblocks a full queue.
  assign alloc_ready = reset && (cp_count < PW'(CP_SIZE)) && !mispredict;
  assign alloc_fire  = alloc_req && alloc_ready;
  assign alloc_idx   = tail_idx;
  assign check       = alloc_fire;
  assign check_idx   = tail_idx;

  assign recover     = reset && !flush && mispredict;
  assign recover_idx = resolve_idx;

  // Age of the mispredicted slot relative to head; everything at or beyond it is squashed.
  assign misp_off   = resolve_idx - head_idx;
  assign release_ok = valid[head_idx] && done[head_idx] && !(mispredict && misp_off == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else if (flush) begin
      tail  <= head;
      valid <= '0;
      done  <= '0;
    end else begin
      if (mispredict) begin
        for (int i = 0; i < CP_SIZE; i++) begin
          if (IDX_W'(IDX_W'(i) - head_idx) >= misp_off) begin
            valid[i] <= 1'b0;
            done[i]  <= 1'b0;
          end
        end
        tail <= head + PW'(misp_off);
      end else begin
        if (resolve_ok) done[resolve_idx] <= 1'b1;
        if (alloc_fire) begin
          valid[tail_idx] <= 1'b1;
          done[tail_idx]  <= 1'b0;
          tail            <= tail + 1'b1;
        end
      end
      if (release_ok) begin
        valid[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + 1'b1;
      end
    end
  end

`ifdef CP_ALLOC_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_alloc_cnt      <= '0;
      stat_mispredict_cnt <= '0;
      stat_full_stall_cnt <= '0;
    end else begin
      if (alloc_fire && !flush && stat_alloc_cnt != '1)
        stat_alloc_cnt <= stat_alloc_cnt + 1'b1;
      if (recover && stat_mispredict_cnt != '1)
        stat_mispredict_cnt <= stat_mispredict_cnt + 1'b1;
      if (alloc_req && !alloc_ready && stat_full_stall_cnt != '1)
        stat_full_stall_cnt <= stat_full_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cp_alloc.sv
// tb/tb_cp_alloc.sv - table-driven directed bench for cp_alloc
module tb_cp_alloc;

  logic       clock = 1'b0;
  logic       reset, flush, alloc_req, alloc_ready, check;
  logic [2:0] alloc_idx, check_idx, resolve_idx, recover_idx;
  logic       resolve_valid, resolve_mispredict, recover, cp_empty;
  logic [3:0] cp_count;
`ifdef CP_ALLOC_STATS_EN
  logic [31:0] stat_alloc_cnt, stat_mispredict_cnt, stat_full_stall_cnt;
`endif

  cp_alloc #(.CP_SIZE(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .check(check), .check_idx(check_idx),
    .resolve_valid(resolve_valid), .resolve_idx(resolve_idx),
    .resolve_mispredict(resolve_mispredict),
    .recover(recover), .recover_idx(recover_idx),
    .cp_count(cp_count), .cp_empty(cp_empty)
`ifdef CP_ALLOC_STATS_EN
    , .stat_alloc_cnt(stat_alloc_cnt), .stat_mispredict_cnt(stat_mispredict_cnt),
    .stat_full_stall_cnt(stat_full_stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, fl, ar, rv;
    logic [2:0] ri;
    logic       rm;
    logic       e_chk;
    logic [2:0] e_idx;
    logic       e_rdy, e_rec;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rst, fl, ar, rv, input int ri, input logic rm,
                     input logic chk, input int idx, input logic rdy, rec, input int cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ar = ar; v.rv = rv; v.ri = 3'(ri); v.rm = rm;
    v.e_chk = chk; v.e_idx = 3'(idx); v.e_rdy = rdy; v.e_rec = rec; v.e_cnt = 4'(cnt);
    vq.push_back(v);
  endtask

  task automatic cmp(input string name, input int act, input int exp, input int row);
    if (act != exp) begin
      n_err++;
      $display("FAIL row %0d %s: got %0d expected %0d", row, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; flush = v.fl; alloc_req = v.ar;
    resolve_valid = v.rv; resolve_idx = v.ri; resolve_mispredict = v.rm;
  endtask

  task automatic check_vec(input vec_t v, input int row);
    n_vec++;
    cmp("check", int'(check), int'(v.e_chk), row);
    cmp("alloc_ready", int'(alloc_ready), int'(v.e_rdy), row);
    cmp("recover", int'(recover), int'(v.e_rec), row);
    cmp("cp_count", int'(cp_count), int'(v.e_cnt), row);
    cmp("cp_empty", int'(cp_empty), int'(v.e_cnt == 0), row);
    if (v.e_chk) begin
      cmp("alloc_idx", int'(alloc_idx), int'(v.e_idx), row);
      cmp("check_idx", int'(check_idx), int'(v.e_idx), row);
    end
    if (v.e_rec) cmp("recover_idx", int'(recover_idx), int'(v.ri), row);
  endtask

  initial begin
    vec_t v;
    reset = 1'b0; flush = 1'b0; alloc_req = 1'b1;
    resolve_valid = 1'b0; resolve_idx = 3'd0; resolve_mispredict = 1'b0;

    //  rst fl ar rv ri rm | chk idx rdy rec cnt
    add(0,0,1,0,0,0, 0,0,0,0,0);               // second reset cycle, request held
    for (int k = 0; k < 8; k++) add(1,0,1,0,0,0, 1,k,1,0,k);
    add(1,0,1,0,0,0, 0,0,0,0,8);               // full: stall
    add(0,0,0,0,0,0, 0,0,0,0,8);
    // in-order release
    for (int k = 0; k < 3; k++) add(1,0,1,0,0,0, 1,k,1,0,k);
    add(1,0,0,1,1,0, 0,0,1,0,3);
    add(1,0,0,1,0,0, 0,0,1,0,3);
    add(1,0,0,0,0,0, 0,0,1,0,3);
    add(1,0,0,0,0,0, 0,0,1,0,2);
    add(1,0,0,0,0,0, 0,0,1,0,1);
    add(0,0,0,0,0,0, 0,0,0,0,1);
    // mispredict squash
    for (int k = 0; k < 5; k++) add(1,0,1,0,0,0, 1,k,1,0,k);
    add(1,0,1,1,2,1, 0,0,0,1,5);
    add(1,0,1,0,0,0, 1,2,1,0,2);
    add(1,0,0,0,0,0, 0,0,1,0,3);
    add(0,0,0,0,0,0, 0,0,0,0,3);
    // wrap: move head to 4, then fill across the wrap
    for (int k = 0; k < 4; k++) add(1,0,1,0,0,0, 1,k,1,0,k);
    add(1,0,0,1,0,0, 0,0,1,0,4);
    add(1,0,0,1,1,0, 0,0,1,0,4);
    add(1,0,0,1,2,0, 0,0,1,0,3);
    add(1,0,0,1,3,0, 0,0,1,0,2);
    add(1,0,0,0,0,0, 0,0,1,0,1);
    add(1,0,0,0,0,0, 0,0,1,0,0);
    for (int k = 0; k < 8; k++) add(1,0,1,0,0,0, 1,(4+k)%8,1,0,k);
    add(1,0,1,0,0,0, 0,0,0,0,8);
    add(1,0,1,1,4,0, 0,0,0,0,8);
    add(1,0,1,0,0,0, 0,0,0,0,8);               // releases slot 4, still stalled
    add(1,0,1,0,0,0, 1,4,1,0,7);
    add(1,0,0,0,0,0, 0,0,0,0,8);
    add(0,0,0,0,0,0, 0,0,0,0,8);
    // flush beats mispredict; stale resolves ignored
    for (int k = 0; k < 5; k++) add(1,0,1,0,0,0, 1,k,1,0,k);
    add(1,1,0,1,2,1, 0,0,0,0,5);
    add(1,0,0,0,0,0, 0,0,1,0,0);
    add(1,0,0,1,3,0, 0,0,1,0,0);
    add(1,0,1,1,3,1, 1,0,1,0,0);               // mispredict to invalid slot: no recover
    add(1,0,0,1,0,1, 0,0,0,1,1);               // mispredict on lone head slot
    add(1,0,0,0,0,0, 0,0,1,0,0);

    @(posedge clock); #1;
    for (int r = 0; r < vq.size(); r++) begin
      drive(vq[r]);
      @(negedge clock);
      check_vec(vq[r], r);
      @(posedge clock); #1;
    end

    // reset overrides a live queue with a simultaneous request and mispredict
    for (int k = 0; k < 3; k++) begin
      v.rst = 1; v.fl = 0; v.ar = 1; v.rv = 0; v.ri = 0; v.rm = 0;
      v.e_chk = 1; v.e_idx = 3'(k); v.e_rdy = 1; v.e_rec = 0; v.e_cnt = 4'(k);
      drive(v); @(negedge clock); check_vec(v, 1000 + k); @(posedge clock); #1;
    end
    v.rst = 0; v.ar = 1; v.rv = 1; v.ri = 1; v.rm = 1;
    v.e_chk = 0; v.e_rdy = 0; v.e_rec = 0; v.e_cnt = 4'd3;
    drive(v); @(negedge clock); check_vec(v, 1003); @(posedge clock); #1;
    v.rst = 1; v.ar = 1; v.rv = 0; v.rm = 0;
    v.e_chk = 1; v.e_idx = 3'd0; v.e_rdy = 1; v.e_cnt = 4'd0;
    drive(v); @(negedge clock); check_vec(v, 1004); @(posedge clock); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
